// File: rtl/shift_engine.sv
// Full-duplex serial shift engine: parallel load, paced LSB/MSB-first shift-out
// with simultaneous serial capture, one-cycle done pulse on completion.
module shift_engine #(
   parameter int unsigned width = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [width-1:0] load_data,
   input  logic             msb_first,
   input  logic             shift_en,
   input  logic             serial_in,
   output logic             serial_out,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic [width-1:0] out_data
);

   localparam int unsigned cnt_w = $clog2(width + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             r_state;
   logic [width-1:0]   r_shreg;
   logic [cnt_w-1:0]   r_cnt;
   logic               r_dir;
   logic [width-1:0]   r_out;

   state_t             w_state_nxt;
   logic [width-1:0]   w_shreg_nxt;
   logic [cnt_w-1:0]   w_cnt_nxt;
   logic               w_dir_nxt;
   logic [width-1:0]   w_out_nxt;
   logic [width-1:0]   w_shifted;
   logic               w_last;

   // Shift register value after one paced shift in the latched direction
   always_comb begin
      w_shifted = r_dir ? {r_shreg[width-2:0], serial_in}
                        : {serial_in, r_shreg[width-1:1]};
      w_last    = (r_cnt == cnt_w'(width - 1));
   end

   // Next-state and datapath update; abort beats a simultaneous final shift
   always_comb begin
      w_state_nxt = r_state;
      w_shreg_nxt = r_shreg;
      w_cnt_nxt   = r_cnt;
      w_dir_nxt   = r_dir;
      w_out_nxt   = r_out;
      case (r_state)
         IDLE: begin
            if (load_valid) begin
               w_shreg_nxt = load_data;
               w_dir_nxt   = msb_first;
               w_cnt_nxt   = '0;
               w_state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (abort) begin
               w_state_nxt = IDLE;
            end else if (shift_en) begin
               w_shreg_nxt = w_shifted;
               if (w_last) begin
                  w_out_nxt   = w_shifted;
                  w_state_nxt = DONE;
               end else begin
                  w_cnt_nxt = cnt_w'(r_cnt + 1'b1);
               end
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_shreg <= '0;
         r_cnt   <= '0;
         r_dir   <= 1'b0;
         r_out   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_shreg <= w_shreg_nxt;
         r_cnt   <= w_cnt_nxt;
         r_dir   <= w_dir_nxt;
         r_out   <= w_out_nxt;
      end
   end

   // Status outputs decoded from the state register only
   always_comb begin
      load_ready = (r_state == IDLE);
      busy       = (r_state == SHIFT);
      done       = (r_state == DONE);
      out_data   = r_out;
      serial_out = 1'b0;
      if (r_state == SHIFT) begin
         serial_out = r_dir ? r_shreg[width-1] : r_shreg[0];
      end
   end

endmodule

// File: tb/tb_shift_engine.sv
// Directed bench for shift_engine (width=8) with a queue scoreboard of
// expected received words.
module tb_shift_engine;

   logic       clk;
   logic       rst_n;
   logic       load_valid;
   logic       load_ready;
   logic [7:0] load_data;
   logic       msb_first;
   logic       shift_en;
   logic       serial_in;
   logic       serial_out;
   logic       abort;
   logic       busy;
   logic       done;
   logic [7:0] out_data;

   int         n_tests;
   int         n_fail;
   logic [7:0] sb[$];
   logic [7:0] last_out;

   shift_engine #(.width(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .msb_first  (msb_first),
      .shift_en   (shift_en),
      .serial_in  (serial_in),
      .serial_out (serial_out),
      .abort      (abort),
      .busy       (busy),
      .done       (done),
      .out_data   (out_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pop the oldest expected word and compare against out_data
   task automatic sb_check(input string tag);
      logic [7:0] e;
      if (sb.size() == 0) begin
         n_tests++;
         n_fail++;
         $error("FAIL %s: observed done with out_data %0h expected no completion", tag, out_data);
      end else begin
         e = sb.pop_front();
         chk(tag, out_data, e);
         last_out = e;
      end
   endtask

   // One transfer; gap = idle cycles before each shift after the first,
   // abort_at = shift index at which abort is raised (-1 for none)
   task automatic xfer(input logic [7:0] tx, input logic m, input logic [7:0] rx,
                       input int gap, input int abort_at);
      logic bexp;
      chk("ready_idle", load_ready, 1);
      load_valid = 1'b1;
      load_data  = tx;
      msb_first  = m;
      if (abort_at < 0) sb.push_back(rx);
      @(posedge clk); #1;
      load_valid = 1'b0;
      load_data  = 8'h00;
      msb_first  = ~m;
      chk("busy_after_load", busy, 1);
      chk("ready_in_shift", load_ready, 0);
      for (int i = 0; i < 8; i++) begin
         bexp = m ? tx[7-i] : tx[i];
         if (gap > 0 && i > 0) begin
            for (int g = 0; g < gap; g++) begin
               chk("gap_sout", serial_out, bexp);
               chk("gap_nodone", done, 0);
               @(posedge clk); #1;
            end
         end
         chk("sout", serial_out, bexp);
         shift_en  = 1'b1;
         serial_in = m ? rx[7-i] : rx[i];
         abort     = (i == abort_at);
         @(posedge clk); #1;
         shift_en  = 1'b0;
         serial_in = 1'b0;
         if (abort) begin
            abort = 1'b0;
            chk("abort_nodone", done, 0);
            chk("abort_busy", busy, 0);
            chk("abort_ready", load_ready, 1);
            chk("abort_out", out_data, last_out);
            chk("abort_sout", serial_out, 0);
            return;
         end
         if (i < 7) chk("no_early_done", done, 0);
      end
      chk("done_pulse", done, 1);
      chk("busy_in_done", busy, 0);
      chk("ready_in_done", load_ready, 0);
      chk("sout_in_done", serial_out, 0);
      sb_check("out_data");
      @(posedge clk); #1;
      chk("done_one_cycle", done, 0);
      chk("ready_after", load_ready, 1);
   endtask

   initial begin
      int hs_cnt;
      int hs_second;
      n_tests    = 0;
      n_fail     = 0;
      last_out   = 8'h00;
      rst_n      = 1'b0;
      load_valid = 1'b0;
      load_data  = 8'h00;
      msb_first  = 1'b0;
      shift_en   = 1'b0;
      serial_in  = 1'b0;
      abort      = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_out", out_data, 8'h00);
      chk("rst_sout", serial_out, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_ready", load_ready, 1);

      // LSB-first, continuous pacing
      xfer(8'hA5, 1'b0, 8'h3C, 0, -1);
      // Abort after 3 shifts, then abort together with the 8th shift
      xfer(8'h5A, 1'b0, 8'hFF, 0, 3);
      xfer(8'h77, 1'b1, 8'h81, 0, 7);
      // MSB-first
      xfer(8'hA5, 1'b1, 8'h96, 0, -1);
      // Gapped pacing 1,0,0,1,0,0,...
      xfer(8'hF0, 1'b0, 8'h5A, 2, -1);

      // load_valid held high across two words; second accepted 10 cycles later
      hs_cnt     = 0;
      hs_second  = -1;
      load_valid = 1'b1;
      load_data  = 8'h11;
      msb_first  = 1'b0;
      shift_en   = 1'b1;
      for (int k = 0; k <= 20; k++) begin
         chk("b2b_ready", load_ready, (k % 10 == 0));
         chk("b2b_done", done, (k % 10 == 9));
         if (done) sb_check("b2b_out");
         if (k == 20) load_valid = 1'b0;
         serial_in = (k < 10);
         if (load_ready && load_valid) begin
            sb.push_back((k < 10) ? 8'hFF : 8'h00);
            if (hs_cnt == 1) hs_second = k;
            hs_cnt++;
         end
         if (k == 1) load_data = 8'h22;
         @(posedge clk); #1;
      end
      shift_en  = 1'b0;
      serial_in = 1'b0;
      chk("b2b_handshakes", hs_cnt, 2);
      chk("b2b_period", hs_second, 10);

      // Asynchronous reset mid-transfer after 4 shifts
      load_valid = 1'b1;
      load_data  = 8'h5A;
      msb_first  = 1'b0;
      @(posedge clk); #1;
      load_valid = 1'b0;
      shift_en   = 1'b1;
      serial_in  = 1'b1;
      repeat (4) @(posedge clk);
      #3;
      chk("pre_rst_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_out", out_data, 8'h00);
      chk("arst_sout", serial_out, 0);
      sb.delete();
      last_out  = 8'h00;
      shift_en  = 1'b0;
      serial_in = 1'b0;
      #3;
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         chk("post_rst_nodone", done, 0);
      end
      xfer(8'hC3, 1'b1, 8'h69, 0, -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/shift_engine.md
Name: shift_engine

Overview:
Parametrised, full-duplex serial shift engine; successor to the plain enable-gated shift register.
- Accepts a parallel word through a valid/ready handshake.
- Shifts the word out serially, LSB-first or MSB-first (selected per transfer), while capturing serial_in into the vacated bits.
- After exactly `width` paced shifts, presents the received word with a one-cycle done pulse.
- Used as the datapath core for serial links and bit-serial peripherals in the design.

Parameters:
width, 8, word length in bits; legal range width >= 2.
cnt_w, $clog2(width+1), shift counter width; derived, not overridden.

Ports:
clk  in  1  system clock; all state changes on posedge.
rst_n  in  1  asynchronous active-low reset.
load_valid  in  1  parallel word offered.
load_ready  out  1  engine can accept a word (high only in IDLE).
load_data  in  width  word to transmit.
msb_first  in  1  direction for this transfer; sampled only on load handshake.
shift_en  in  1  pacing strobe; one shift per cycle it is high in SHIFT.
serial_in  in  1  incoming serial bit; captured on each paced shift.
serial_out  out  1  current outgoing bit (combinational from register).
abort  in  1  cancel the transfer in progress.
busy  out  1  high in SHIFT.
done  out  1  one-cycle pulse; received word valid on out_data.
out_data  out  width  last completed received word; held until the next completion.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; shreg=0; cnt=0; dir_q=0.
  - out_data=0; done=0; busy=0.
  - load_ready=1 once rst_n is high.
  - serial_out=0.
  - A transfer in progress is discarded with no done pulse.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - load_ready=1.
  - On load_valid&&load_ready: shreg<=load_data, dir_q<=msb_first, cnt<=0, next state SHIFT.
  - shift_en and abort are ignored.
- SHIFT:
  - busy=1, load_ready=0; load_valid is ignored (no queueing).
  - serial_out = dir_q ? shreg[width-1] : shreg[0].
  - serial_out is 0 in IDLE and DONE.
- Paced shift in SHIFT (shift_en=1, abort=0):
  - dir_q=0: shreg <= {serial_in, shreg[width-1:1]}.
  - dir_q=1: shreg <= {shreg[width-2:0], serial_in}.
  - cnt <= cnt+1.
  - shift_en=0: shreg and cnt hold; no timeout.
- Completion:
  - On the paced shift with cnt==width-1: out_data<=post-shift shreg value, next state DONE.
  - Exactly `width` shifts per transfer.
- DONE:
  - Lasts exactly one cycle; done=1, busy=0, load_ready=0.
  - Next state IDLE unconditionally.
- Abort:
  - abort=1 in SHIFT: next state IDLE, no shift that cycle, no done, out_data unchanged.
  - abort has priority over a simultaneous final shift.
- Latency: handshake edge to done-high edge = width paced shifts + 0 extra cycles; done occupies the cycle after the last shift edge. Minimum back-to-back period = width+2 cycles (load, width shifts, DONE).
- Registered outputs: done, busy, load_ready, out_data (all decoded from registered state or registered directly; no combinational path from inputs). serial_out is the only combinational output, driven from registers only.
- Counter: cnt never exceeds width-1 and never wraps; cnt is cleared on load.
- Unknown or unused state encodings recover to IDLE.

Test Plan:
- width=8, load 0xA5 msb_first=0, shift_en held 1, serial_in driven LSB-first from 0x3C -> serial_out 1,0,1,0,0,1,0,1; done high one cycle after the 8th shift edge; out_data=0x3C; load_ready=1 the following cycle.
- Load 0xA5 msb_first=1, serial_in MSB-first from 0x96 -> serial_out 1,0,1,0,0,1,0,1; out_data=0x96.
- Load 0xF0 msb_first=0, shift_en toggling 1,0,0,1,... -> serial_out holds across gaps; exactly 8 shifts; done only after the 8th enabled cycle; out_data equals the 8 captured bits.
- Abort after 3 shifts (prior out_data=0x3C) -> no done, out_data stays 0x3C, load_ready=1 the next cycle. Abort asserted together with the 8th shift -> no done, out_data unchanged.
- load_valid held high continuously with words 0x11 then 0x22 -> second word is accepted only in the IDLE cycle after DONE; period = 10 cycles; load_valid during SHIFT/DONE is never accepted.
- rst_n pulsed low asynchronously (mid-cycle) after 4 shifts -> immediately busy=0, done=0, out_data=0, serial_out=0; no done pulse follows; a new load then completes normally.
